// File: rtl/dmem_rsp_pkg.sv
// rtl/dmem_rsp_pkg.sv - shared types and funct3 constants for the data-memory responder
package dmem_rsp_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Widest byte address the request struct can carry; ADDR_W must not exceed it.
  localparam int REQ_ADDR_W = 16;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} dmem_state_t;

  typedef struct packed {
    logic                  write;
    logic [REQ_ADDR_W-1:0] addr;
    logic [31:0]           wdata;
    logic [2:0]            funct3;
  } dmem_req_t;

  function automatic logic f3_illegal(input logic write, input logic [2:0] f3);
    if (write) return (f3 > F3_W);
    return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// rtl/dmem_lane_align.sv - store byte-enable/data steering and load lane extraction/extension
// Optional DMEM_MISALIGN_CHK_EN flags misaligned halfword/word accesses as errors.
module dmem_lane_align
  import dmem_rsp_pkg::*;
(
  input  logic        i_write,
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rword,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata,
  output logic        o_err
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic        w_misalign;

  assign w_byte = i_rword[{i_addr_lo, 3'b000} +: 8];
  assign w_half = i_addr_lo[1] ? i_rword[31:16] : i_rword[15:0];

`ifdef DMEM_MISALIGN_CHK_EN
  assign w_misalign = ((i_funct3[1:0] == 2'b01) && i_addr_lo[0]) ||
                      ((i_funct3[1:0] == 2'b10) && (i_addr_lo != 2'b00));
`else
  assign w_misalign = 1'b0;
`endif

  assign o_err = f3_illegal(i_write, i_funct3) || w_misalign;

  always_comb begin
    o_be    = 4'b0000;
    o_wdata = 32'h0;
    o_rdata = 32'h0;
    if (!o_err) begin
      if (i_write) begin
        // Replicated data lets the byte-enables alone pick the destination lanes.
        unique case (i_funct3)
          F3_B: begin
            o_be    = 4'b0001 << i_addr_lo;
            o_wdata = {4{i_wdata[7:0]}};
          end
          F3_H: begin
            o_be    = i_addr_lo[1] ? 4'b1100 : 4'b0011;
            o_wdata = {2{i_wdata[15:0]}};
          end
          default: begin
            o_be    = 4'b1111;
            o_wdata = i_wdata;
          end
        endcase
      end else begin
        unique case (i_funct3)
          F3_B:    o_rdata = {{24{w_byte[7]}}, w_byte};
          F3_BU:   o_rdata = {24'h0, w_byte};
          F3_H:    o_rdata = {{16{w_half[15]}}, w_half};
          F3_HU:   o_rdata = {16'h0, w_half};
          default: o_rdata = i_rword;
        endcase
      end
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - multi-cycle data-memory responder with wait states and RV32I lane handling
// Optional DMEM_MISALIGN_CHK_EN (handled in dmem_lane_align) rejects misaligned accesses.
module dmem_responder
  import dmem_rsp_pkg::*;
#(
  parameter int ADDR_W      = 9,
  parameter int DATA_W      = 32,
  parameter int DEPTH_WORDS = 128,
  parameter int WAIT_STATES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [2:0]        req_funct3,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  dmem_state_t r_state;
  dmem_state_t w_next_state;
  dmem_req_t   r_req;
  logic [3:0]  r_cnt;
  logic [31:0] r_rdata;
  logic        r_err;
  logic [31:0] r_mem [DEPTH_WORDS];

  logic              w_accept;
  logic              w_access;
  logic [ADDR_W-3:0] w_widx;
  logic [31:0]       w_rword;
  logic [3:0]        w_be;
  logic [31:0]       w_wdata_sh;
  logic [31:0]       w_lane_rdata;
  logic              w_lane_err;
  logic              w_unused_addr;

  always_comb begin
    w_next_state = r_state;
    req_ready    = 1'b0;
    rsp_valid    = 1'b0;
    unique case (r_state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) w_next_state = BUSY;
      end
      BUSY: begin
        if (r_cnt == 4'd0) w_next_state = RESP;
      end
      RESP: begin
        rsp_valid    = 1'b1;
        req_ready    = 1'b1;
        w_next_state = req_valid ? BUSY : IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next_state;
  end

  assign w_accept = req_valid && req_ready;
  assign w_access = (r_state == BUSY) && (r_cnt == 4'd0);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_req   <= '0;
      r_cnt   <= 4'd0;
      r_rdata <= 32'h0;
      r_err   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_req <= '{write:  req_write,
                   addr:   REQ_ADDR_W'(req_addr),
                   wdata:  32'(req_wdata),
                   funct3: req_funct3};
        r_cnt <= 4'(WAIT_STATES);
      end else if ((r_state == BUSY) && (r_cnt != 4'd0)) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_access) begin
        r_rdata <= w_lane_rdata;
        r_err   <= w_lane_err;
      end
    end
  end

  assign w_widx        = r_req.addr[ADDR_W-1:2];
  assign w_rword       = r_mem[w_widx];
  assign w_unused_addr = ^r_req.addr;

  dmem_lane_align u_lane_align (
    .i_write   (r_req.write),
    .i_funct3  (r_req.funct3),
    .i_addr_lo (r_req.addr[1:0]),
    .i_wdata   (r_req.wdata),
    .i_rword   (w_rword),
    .o_be      (w_be),
    .o_wdata   (w_wdata_sh),
    .o_rdata   (w_lane_rdata),
    .o_err     (w_lane_err)
  );

  // Reset wins over a commit sampled on the same edge, so a store racing reset is dropped.
  always_ff @(posedge clk) begin
    if (!reset && w_access) begin
      for (int i = 0; i < 4; i++) begin
        if (w_be[i]) r_mem[w_widx][8*i +: 8] <= w_wdata_sh[8*i +: 8];
      end
    end
  end

  assign rsp_rdata = DATA_W'(r_rdata);
  assign rsp_err   = r_err;

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - self-checking bench for dmem_responder against a byte-array model
module tb_dmem_responder;

  localparam int WS = 1;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [8:0]  req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [2:0]  req_funct3 = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  always #5 clk = ~clk;

  dmem_responder #(
    .ADDR_W(9), .DATA_W(32), .DEPTH_WORDS(128), .WAIT_STATES(WS)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_funct3(req_funct3),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  int checks = 0;
  int failures = 0;
  int n_issued = 0;
  int n_pulses = 0;
  logic [7:0] bmem [512];

  always @(posedge clk) if (!reset && rsp_valid === 1'b1) n_pulses++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Access semantics from the ISA rules on a flat byte array.
  task automatic model_access(input logic w, input logic [8:0] a, input logic [31:0] d,
                              input logic [2:0] f3, output logic [31:0] rd, output logic er);
    int size, base;
    logic [31:0] val;
    bit ill;
    ill  = w ? (f3 > 3'd2) : (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
    size = 1 << f3[1:0];
`ifdef DMEM_MISALIGN_CHK_EN
    if (!ill && (int'(a) % size) != 0) ill = 1;
`endif
    rd = 32'h0;
    er = ill;
    if (ill) return;
    base = int'(a) - (int'(a) % size);
    if (w) begin
      for (int i = 0; i < size; i++) bmem[base+i] = d[8*i +: 8];
    end else begin
      val = 32'h0;
      for (int i = 0; i < size; i++) val = val | (32'(bmem[base+i]) << (8*i));
      if (!f3[2] && size < 4 && val[8*size-1]) val = val | ~((32'd1 << (8*size)) - 32'd1);
      rd = val;
    end
  endtask

  task automatic access(input logic w, input logic [8:0] a, input logic [31:0] d,
                        input logic [2:0] f3, output logic [31:0] rd, output logic er,
                        output int lat, output logic rdy_bad);
    int n;
    @(negedge clk);
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; req_funct3 = f3;
    n = 0;
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    @(posedge clk); #1 req_valid = 1'b0;
    lat = 0; rdy_bad = 1'b0; rd = 'x; er = 1'bx;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (rsp_valid) begin lat = k; rd = rsp_rdata; er = rsp_err; break; end
      if (req_ready) rdy_bad = 1'b1;
    end
  endtask

  task automatic op(input string nm, input logic w, input logic [8:0] a, input logic [31:0] d,
                    input logic [2:0] f3, input logic [31:0] exp_rd, input logic exp_er);
    logic [31:0] rd; logic er, rb; int lat;
    access(w, a, d, f3, rd, er, lat, rb);
    n_issued++;
    chk({nm, " rdata"}, rd, exp_rd);
    chk({nm, " err"}, 32'(er), 32'(exp_er));
    chk({nm, " latency"}, lat, WS + 2);
    chk({nm, " ready_in_busy"}, 32'(rb), 32'h0);
  endtask

  typedef struct {
    logic        w;
    logic [8:0]  a;
    logic [31:0] d;
    logic [2:0]  f3;
    logic [31:0] exp_rd;
    logic        exp_er;
  } vec_t;

  vec_t vecs[16];

  initial begin
    logic [31:0] mrd, rd, rd_b; logic mer, rdy, bad; int lat;
    logic w; logic [8:0] a; logic [31:0] d; logic [2:0] f3;

    vecs[0]  = '{1'b1, 9'h010, 32'hDEADBEEF, 3'b010, 32'h0,        1'b0};
    vecs[1]  = '{1'b0, 9'h010, 32'h0,        3'b010, 32'hDEADBEEF, 1'b0};
    vecs[2]  = '{1'b1, 9'h013, 32'h00000080, 3'b000, 32'h0,        1'b0};
    vecs[3]  = '{1'b0, 9'h013, 32'h0,        3'b000, 32'hFFFFFF80, 1'b0};
    vecs[4]  = '{1'b0, 9'h013, 32'h0,        3'b100, 32'h00000080, 1'b0};
    vecs[5]  = '{1'b0, 9'h010, 32'h0,        3'b010, 32'h80ADBEEF, 1'b0};
    vecs[6]  = '{1'b1, 9'h022, 32'h00008001, 3'b001, 32'h0,        1'b0};
    vecs[7]  = '{1'b0, 9'h022, 32'h0,        3'b001, 32'hFFFF8001, 1'b0};
    vecs[8]  = '{1'b0, 9'h022, 32'h0,        3'b101, 32'h00008001, 1'b0};
    vecs[9]  = '{1'b0, 9'h020, 32'h0,        3'b010, 32'h80010000, 1'b0};
    vecs[10] = '{1'b1, 9'h030, 32'hCAFEF00D, 3'b010, 32'h0,        1'b0};
    vecs[11] = '{1'b1, 9'h030, 32'hFFFFFFFF, 3'b011, 32'h0,        1'b1};
    vecs[12] = '{1'b0, 9'h030, 32'h0,        3'b010, 32'hCAFEF00D, 1'b0};
    vecs[13] = '{1'b0, 9'h030, 32'h0,        3'b110, 32'h0,        1'b1};
    vecs[14] = '{1'b0, 9'h010, 32'h0,        3'b001, 32'hFFFFBEEF, 1'b0};
    vecs[15] = '{1'b0, 9'h012, 32'h0,        3'b101, 32'h000080AD, 1'b0};

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("reset req_ready", 32'(req_ready), 32'h1);
    chk("reset rsp_valid", 32'(rsp_valid), 32'h0);
    chk("reset rsp_rdata", rsp_rdata, 32'h0);
    chk("reset rsp_err", 32'(rsp_err), 32'h0);

    // Storage is not reset, so give every word a known value first.
    for (int i = 0; i < 128; i++) begin
      access(1'b1, 9'(i*4), 32'h0, 3'b010, rd, mer, lat, bad);
      n_issued++;
      model_access(1'b1, 9'(i*4), 32'h0, 3'b010, mrd, mer);
    end

    for (int i = 0; i < 16; i++) begin
      model_access(vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].f3, mrd, mer);
      op($sformatf("vec%0d", i), vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].f3,
         vecs[i].exp_rd, vecs[i].exp_er);
    end

    // Back-to-back: second request is held valid and taken in the RESP cycle.
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 9'h100; req_wdata = 32'h11223344; req_funct3 = 3'b010;
    while (!req_ready) @(negedge clk);
    @(posedge clk); #1;
    req_write = 1'b0; req_wdata = 32'h0;
    lat = 0; bad = 1'b0; rd = 'x; rdy = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (rsp_valid) begin lat = k; rd = rsp_rdata; rdy = req_ready; break; end
      if (req_ready) bad = 1'b1;
    end
    chk("b2b first latency", lat, WS + 2);
    chk("b2b first rdata", rd, 32'h0);
    chk("b2b ready in RESP", 32'(rdy), 32'h1);
    @(posedge clk); #1 req_valid = 1'b0;
    lat = 0; rd_b = 'x;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (rsp_valid) begin lat = k; rd_b = rsp_rdata; break; end
      if (req_ready) bad = 1'b1;
    end
    chk("b2b second latency", lat, WS + 2);
    chk("b2b second rdata", rd_b, 32'h11223344);
    chk("b2b ready in busy", 32'(bad), 32'h0);
    n_issued += 2;
    model_access(1'b1, 9'h100, 32'h11223344, 3'b010, mrd, mer);

    // Reset sampled on the commit edge of a store: store dropped, no response.
    model_access(1'b1, 9'h040, 32'hA5A55A5A, 3'b010, mrd, mer);
    op("pre-reset SW", 1'b1, 9'h040, 32'hA5A55A5A, 3'b010, 32'h0, 1'b0);
    op("pre-reset LW", 1'b0, 9'h040, 32'h0, 3'b010, 32'hA5A55A5A, 1'b0);
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 9'h040; req_wdata = 32'h12345678; req_funct3 = 3'b010;
    while (!req_ready) @(negedge clk);
    @(posedge clk); #1 req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("mid-reset req_ready", 32'(req_ready), 32'h1);
    chk("mid-reset rsp_valid", 32'(rsp_valid), 32'h0);
    chk("mid-reset rsp_rdata", rsp_rdata, 32'h0);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    chk("no response after reset", 32'(rsp_valid), 32'h0);
    op("post-reset LW", 1'b0, 9'h040, 32'h0, 3'b010, 32'hA5A55A5A, 1'b0);
`ifdef DMEM_MISALIGN_CHK_EN
    op("misaligned LW", 1'b0, 9'h042, 32'h0, 3'b010, 32'h0, 1'b1);
`else
    op("misaligned LW", 1'b0, 9'h042, 32'h0, 3'b010, 32'hA5A55A5A, 1'b0);
`endif

    for (int i = 0; i < 200; i++) begin
      w  = 1'($urandom_range(0, 1));
      a  = 9'($urandom_range(0, 511));
      f3 = 3'($urandom_range(0, 7));
      d  = $urandom;
      model_access(w, a, d, f3, mrd, mer);
      op($sformatf("rand%0d w=%0d a=%h f3=%0d", i, w, a, f3), w, a, d, f3, mrd, mer);
    end

    @(negedge clk);
    chk("response count", n_pulses, n_issued);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
